// File: rtl/flash_score_store_pkg.sv
// Shared types and record layout for the flash-backed score store.
package flash_store_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_FINISH
    } state_e;

    localparam int REC_LEN = 4;

    localparam logic [1:0] OFS_MAGIC = 2'd0;
    localparam logic [1:0] OFS_A     = 2'd1;
    localparam logic [1:0] OFS_B     = 2'd2;
    localparam logic [1:0] OFS_SUM   = 2'd3;

    function automatic logic [7:0] rec_sum(input logic [7:0] magic,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        return magic ^ a ^ b;
    endfunction

endpackage

// File: rtl/flash_score_store_if.sv
// Request/response bus between the score store (master) and the flash bridge (slave).
interface flash_score_store_if;
    logic [7:0] fb_addr;
    logic [7:0] fb_data_wr;
    logic [7:0] fb_data_rd;
    logic       fb_dir_rw;
    logic       fb_start;
    logic       fb_done;

    modport master (
        output fb_addr, fb_data_wr, fb_dir_rw, fb_start,
        input  fb_data_rd, fb_done
    );

    modport slave (
        input  fb_addr, fb_data_wr, fb_dir_rw, fb_start,
        output fb_data_rd, fb_done
    );
endinterface

// File: rtl/flash_score_store_watchdog.sv
// Per-access watchdog: loadable 8-bit down-counter that flags when the budget runs out.
module flash_access_watchdog (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       enable_i,
    output logic       expired_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (enable_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle in which the count steps down to zero.
    assign expired_o = enable_i && (cnt_q <= 8'd1);
endmodule

// File: rtl/flash_score_store.sv
// Saves/loads two 8-bit scores as a 4-byte framed record (magic, A, B, checksum)
// through the flash bridge start/done handshake.
module flash_score_store
    import flash_store_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       load_req_i,
    input  logic       save_req_i,
    input  logic [7:0] score_a_i,
    input  logic [7:0] score_b_i,
    output logic [7:0] score_a_o,
    output logic [7:0] score_b_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    flash_score_store_if.master fb
);
    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       dir_q, dir_d;
    logic [7:0] lat_a_q, lat_a_d;
    logic [7:0] lat_b_q, lat_b_d;
    logic [7:0] sh_magic_q, sh_magic_d;
    logic [7:0] sh_a_q, sh_a_d;
    logic [7:0] sh_b_q, sh_b_d;
    logic [7:0] score_a_q, score_a_d;
    logic [7:0] score_b_q, score_b_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    logic       wd_load;
    logic       wd_en;
    logic       wd_expired;
    logic       rec_ok;
    logic       in_access;
    logic [7:0] wr_byte;

    // The ISSUE cycle consumes one tick of the budget, so the watchdog starts one lower.
    flash_access_watchdog u_wd (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .load_i     (wd_load),
        .load_val_i (8'(TIMEOUT - 1)),
        .enable_i   (wd_en),
        .expired_o  (wd_expired)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            dir_q      <= 1'b1;
            lat_a_q    <= 8'd0;
            lat_b_q    <= 8'd0;
            sh_magic_q <= 8'd0;
            sh_a_q     <= 8'd0;
            sh_b_q     <= 8'd0;
            score_a_q  <= 8'd0;
            score_b_q  <= 8'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            lat_a_q    <= lat_a_d;
            lat_b_q    <= lat_b_d;
            sh_magic_q <= sh_magic_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            score_a_q  <= score_a_d;
            score_b_q  <= score_b_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Checksum byte is taken straight off the bus in the last CAPTURE cycle.
    assign rec_ok = (sh_magic_q == MAGIC) &&
                    (fb.fb_data_rd == rec_sum(sh_magic_q, sh_a_q, sh_b_q));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        lat_a_d    = lat_a_q;
        lat_b_d    = lat_b_q;
        sh_magic_d = sh_magic_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        score_a_d  = score_a_q;
        score_b_d  = score_b_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            ST_IDLE: begin
                if (save_req_i || load_req_i) begin
                    state_d = ST_ISSUE;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    idx_d   = 2'd0;
                    dir_d   = ~save_req_i;
                    if (save_req_i) begin
                        lat_a_d = score_a_i;
                        lat_b_d = score_b_i;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fb.fb_done) begin
                    state_d = ST_CAPTURE;
                end else if (wd_expired) begin
                    state_d = ST_FINISH;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (dir_q) begin
                    case (idx_q)
                        OFS_MAGIC: sh_magic_d = fb.fb_data_rd;
                        OFS_A:     sh_a_d     = fb.fb_data_rd;
                        OFS_B:     sh_b_d     = fb.fb_data_rd;
                        default:   ;
                    endcase
                end
                if (idx_q == OFS_SUM) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!dir_q) begin
                        score_a_d = lat_a_q;
                        score_b_d = lat_b_q;
                        valid_d   = 1'b1;
                    end else if (rec_ok) begin
                        score_a_d = sh_a_q;
                        score_b_d = sh_b_q;
                        valid_d   = 1'b1;
                    end else begin
                        score_a_d = 8'd0;
                        score_b_d = 8'd0;
                        valid_d   = 1'b0;
                        error_d   = 1'b1;
                    end
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        case (idx_q)
            OFS_MAGIC: wr_byte = MAGIC;
            OFS_A:     wr_byte = lat_a_q;
            OFS_B:     wr_byte = lat_b_q;
            default:   wr_byte = rec_sum(MAGIC, lat_a_q, lat_b_q);
        endcase
    end

    // Outside an access the bus is parked in read direction so the bridge keeps data tri-stated.
    always_comb begin
        in_access     = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
        fb.fb_start   = (state_q == ST_ISSUE);
        fb.fb_addr    = in_access ? (BASE_ADDR + {6'd0, idx_q}) : 8'd0;
        fb.fb_dir_rw  = in_access ? dir_q : 1'b1;
        fb.fb_data_wr = (in_access && !dir_q) ? wr_byte : 8'd0;
        wd_load       = (state_q == ST_ISSUE);
        wd_en         = (state_q == ST_WAIT);
    end

    assign score_a_o = score_a_q;
    assign score_b_o = score_b_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
endmodule

// File: tb/tb_flash_score_store.sv
// Directed bench for flash_score_store with a latency-configurable flash bridge model.
module tb_flash_score_store;
    logic       CLK_50MHZ = 1'b0;
    logic       RST;
    logic       load_req;
    logic       save_req;
    logic [7:0] score_a_in;
    logic [7:0] score_b_in;
    logic [7:0] score_a_out;
    logic [7:0] score_b_out;
    logic       valid;
    logic       busy;
    logic       done;
    logic       error;

    int n_chk = 0;
    int n_err = 0;

    flash_score_store_if fb_if ();

    flash_score_store #(
        .BASE_ADDR (8'h10),
        .MAGIC     (8'hA5),
        .TIMEOUT   (10)
    ) dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .load_req_i (load_req),
        .save_req_i (save_req),
        .score_a_i  (score_a_in),
        .score_b_i  (score_b_in),
        .score_a_o  (score_a_out),
        .score_b_o  (score_b_out),
        .valid_o    (valid),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .fb         (fb_if)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    // Bridge model: fb_done L cycles after fb_start, read data one cycle after fb_done.
    logic [7:0] mem [0:255];
    int         lat       = 5;
    int         drop_addr = -1;
    logic       act       = 1'b0;
    int         rem       = 0;
    logic [7:0] a_lat     = 8'd0;
    logic [7:0] d_lat     = 8'd0;
    logic       dir_lat   = 1'b1;
    logic       poke_en   = 1'b0;
    logic [7:0] poke_addr = 8'd0;
    logic [7:0] poke_val  = 8'd0;

    always @(posedge CLK_50MHZ) begin
        fb_if.fb_done <= 1'b0;
        if (fb_if.fb_done === 1'b1 && dir_lat) fb_if.fb_data_rd <= mem[a_lat];
        if (poke_en) mem[poke_addr] <= poke_val;
        if (fb_if.fb_start) begin
            act     <= 1'b1;
            rem     <= lat - 1;
            a_lat   <= fb_if.fb_addr;
            d_lat   <= fb_if.fb_data_wr;
            dir_lat <= fb_if.fb_dir_rw;
        end else if (act) begin
            if (rem == 1) begin
                act <= 1'b0;
                if (int'(a_lat) != drop_addr) begin
                    fb_if.fb_done <= 1'b1;
                    if (!dir_lat) mem[a_lat] <= d_lat;
                end
            end else begin
                rem <= rem - 1;
            end
        end
    end

    // Bus monitor, sampled on the falling edge.
    int   cyc_cnt = 0;
    int   n_start = 0;
    int   n_rd    = 0;
    int   n_b2b   = 0;
    int   n_done  = 0;
    int   last_start_cyc = 0;
    int   last_done_cyc  = 0;
    logic prev_start = 1'b0;

    always @(negedge CLK_50MHZ) begin
        cyc_cnt = cyc_cnt + 1;
        if (fb_if.fb_start === 1'b1) begin
            n_start = n_start + 1;
            if (fb_if.fb_dir_rw) n_rd = n_rd + 1;
            if (prev_start) n_b2b = n_b2b + 1;
            last_start_cyc = cyc_cnt;
        end
        prev_start = (fb_if.fb_start === 1'b1);
        if (done === 1'b1) begin
            n_done = n_done + 1;
            last_done_cyc = cyc_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues a request and returns the request-to-done distance in cycles (-1 on no done).
    task automatic do_req(input logic sv, input logic ld, input logic [7:0] a,
                          input logic [7:0] b, input int inj_load, output int cyc);
        @(negedge CLK_50MHZ);
        save_req   = sv;
        load_req   = ld;
        score_a_in = a;
        score_b_in = b;
        cyc = 0;
        forever begin
            @(negedge CLK_50MHZ);
            cyc = cyc + 1;
            save_req = 1'b0;
            load_req = (cyc == inj_load);
            if (done === 1'b1) break;
            if (cyc >= 400) begin
                cyc = -1;
                break;
            end
        end
        load_req = 1'b0;
    endtask

    initial begin
        int cyc;
        int s0;
        int r0;
        int d0;
        int guard;

        RST = 1'b1;
        load_req = 1'b0;
        save_req = 1'b0;
        score_a_in = 8'd0;
        score_b_in = 8'd0;
        repeat (3) @(negedge CLK_50MHZ);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_scores", {16'h0, score_a_out, score_b_out}, 32'h0);
        chk("rst_start", 32'(fb_if.fb_start), 32'h0);
        chk("rst_addr", 32'(fb_if.fb_addr), 32'h0);
        chk("rst_dir", 32'(fb_if.fb_dir_rw), 32'h1);
        chk("rst_wdata", 32'(fb_if.fb_data_wr), 32'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK_50MHZ);

        // Save 07/03
        s0 = n_start; r0 = n_rd;
        do_req(1'b1, 1'b0, 8'h07, 8'h03, 0, cyc);
        chk("save_latency", 32'(cyc), 32'd29);
        chk("save_valid", 32'(valid), 32'h1);
        chk("save_error", 32'(error), 32'h0);
        chk("save_scores", {16'h0, score_a_out, score_b_out}, 32'h0703);
        chk("save_busy", 32'(busy), 32'h0);
        chk("save_m10", 32'(mem[8'h10]), 32'hA5);
        chk("save_m11", 32'(mem[8'h11]), 32'h07);
        chk("save_m12", 32'(mem[8'h12]), 32'h03);
        chk("save_m13", 32'(mem[8'h13]), 32'hA1);
        chk("save_starts", 32'(n_start - s0), 32'd4);
        chk("save_reads", 32'(n_rd - r0), 32'd0);

        // Load it back
        s0 = n_start; r0 = n_rd;
        do_req(1'b0, 1'b1, 8'hEE, 8'hEE, 0, cyc);
        chk("load_latency", 32'(cyc), 32'd29);
        chk("load_scores", {16'h0, score_a_out, score_b_out}, 32'h0703);
        chk("load_valid", 32'(valid), 32'h1);
        chk("load_error", 32'(error), 32'h0);
        chk("load_starts", 32'(n_start - s0), 32'd4);
        chk("load_reads", 32'(n_rd - r0), 32'd4);

        // Corrupt checksum byte
        @(negedge CLK_50MHZ);
        poke_addr = 8'h13; poke_val = 8'h00; poke_en = 1'b1;
        @(negedge CLK_50MHZ);
        poke_en = 1'b0;
        do_req(1'b0, 1'b1, 8'h00, 8'h00, 0, cyc);
        chk("bad_latency", 32'(cyc), 32'd29);
        chk("bad_error", 32'(error), 32'h1);
        chk("bad_valid", 32'(valid), 32'h0);
        chk("bad_scores", {16'h0, score_a_out, score_b_out}, 32'h0000);

        // Save and load together, plus a load pulse while busy
        s0 = n_start; r0 = n_rd;
        do_req(1'b1, 1'b1, 8'h12, 8'h34, 3, cyc);
        chk("coll_latency", 32'(cyc), 32'd29);
        repeat (3) @(negedge CLK_50MHZ);
        chk("coll_starts", 32'(n_start - s0), 32'd4);
        chk("coll_reads", 32'(n_rd - r0), 32'd0);
        chk("coll_busy", 32'(busy), 32'h0);
        chk("coll_scores", {16'h0, score_a_out, score_b_out}, 32'h1234);
        chk("coll_valid", 32'(valid), 32'h1);
        chk("coll_error", 32'(error), 32'h0);
        chk("coll_m11", 32'(mem[8'h11]), 32'h12);
        chk("coll_m12", 32'(mem[8'h12]), 32'h34);
        chk("coll_m13", 32'(mem[8'h13]), 32'h83);

        // Reset during WAIT of byte 1
        s0 = n_start;
        @(negedge CLK_50MHZ);
        load_req = 1'b1;
        @(negedge CLK_50MHZ);
        load_req = 1'b0;
        guard = 0;
        while ((n_start - s0) < 2 && guard < 100) begin
            @(negedge CLK_50MHZ);
            guard = guard + 1;
        end
        chk("mrst_reached_byte1", 32'(guard < 100), 32'h1);
        repeat (2) @(negedge CLK_50MHZ);
        d0 = n_done;
        RST = 1'b1;
        @(negedge CLK_50MHZ);
        chk("mrst_start", 32'(fb_if.fb_start), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_dir", 32'(fb_if.fb_dir_rw), 32'h1);
        chk("mrst_done", 32'(done), 32'h0);
        RST = 1'b0;
        repeat (12) @(negedge CLK_50MHZ);
        chk("mrst_no_done", 32'(n_done - d0), 32'd0);
        chk("mrst_idle", 32'(busy), 32'h0);
        do_req(1'b0, 1'b1, 8'h00, 8'h00, 0, cyc);
        chk("mrst_load_latency", 32'(cyc), 32'd29);
        chk("mrst_load_scores", {16'h0, score_a_out, score_b_out}, 32'h1234);
        chk("mrst_load_valid", 32'(valid), 32'h1);
        chk("mrst_load_error", 32'(error), 32'h0);

        // Bridge never answers byte 2 of a save
        drop_addr = 32'h12;
        s0 = n_start;
        do_req(1'b1, 1'b0, 8'h55, 8'h66, 0, cyc);
        chk("to_error", 32'(error), 32'h1);
        chk("to_scores", {16'h0, score_a_out, score_b_out}, 32'h1234);
        chk("to_valid", 32'(valid), 32'h1);
        @(negedge CLK_50MHZ);
        chk("to_delay", 32'(last_done_cyc - last_start_cyc), 32'd10);
        drop_addr = -1;
        repeat (5) @(negedge CLK_50MHZ);
        chk("to_starts", 32'(n_start - s0), 32'd3);
        chk("to_error_held", 32'(error), 32'h1);

        // Partially written record must fail the checksum
        do_req(1'b0, 1'b1, 8'h00, 8'h00, 0, cyc);
        chk("part_error", 32'(error), 32'h1);
        chk("part_valid", 32'(valid), 32'h0);
        chk("part_scores", {16'h0, score_a_out, score_b_out}, 32'h0000);

        chk("no_back_to_back_start", 32'(n_b2b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/flash_score_store.md
# flash_score_store

Persists the scoreboard state (two 8-bit scores) in parallel NOR flash. It is the client of the flash bridge's `fb_start`/`fb_done` request handshake and issues a framed 4-byte record per save or load. It sits between the score logic and the flash bridge, and verifies a magic byte and a checksum on load.

## Interface
- `BASE_ADDR`, default 8'h10: flash byte address of record byte 0; the record occupies `BASE_ADDR`..`BASE_ADDR+3`, with no wrap check (caller keeps it ≤ 8'hFC).
- `MAGIC`, default 8'hA5: value of record byte 0.
- `TIMEOUT`, default 255: maximum number of cycles `fb_done` may take per access (1..255).

- `CLK_50MHZ` in, 1: clock. Rising edge.
- `RST` in, 1: synchronous, active-high reset.
- `load_req` in, 1: one-cycle pulse; read the record from flash.
- `save_req` in, 1: one-cycle pulse; write the record built from `score_a_in`/`score_b_in`.
- `score_a_in`, `score_b_in` in, 8 each: scores to save, sampled on the accepted `save_req` cycle.
- `score_a_out`, `score_b_out` out, 8 each: last loaded or saved scores.
- `valid` out, 1: the outputs hold a verified record.
- `busy` out, 1: an operation is in progress.
- `done` out, 1: one-cycle pulse when an operation ends.
- `error` out, 1: qualifies `done`; held until the next accepted request.
- `fb_addr` out, 8: bridge address.
- `fb_data_wr` out, 8: bridge write data.
- `fb_data_rd` in, 8: bridge read data.
- `fb_dir_rw` out, 1: 1 = read, 0 = write.
- `fb_start` out, 1: request pulse to the bridge.
- `fb_done` in, 1: bridge completion pulse.

## Operation
- **Record layout:** byte0 = `MAGIC`, byte1 = score A, byte2 = score B, byte3 = `MAGIC ^ A ^ B`.
- **States:** IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- **IDLE:** accepts a request.
  - `save_req` has priority over `load_req` when both are asserted in the same cycle.
  - Requests arriving while `busy` is high are ignored, not queued.
  - On acceptance: clear `error`, set `busy`, set byte index to 0, latch the direction, and latch the input scores on a save.
- **ISSUE:** drive `fb_addr`=`BASE_ADDR`+idx, `fb_dir_rw`, and `fb_data_wr` (save only). Pulse `fb_start` for exactly one cycle, load the watchdog with `TIMEOUT`, go to WAIT.
- **WAIT:** hold `fb_addr`, `fb_dir_rw` and `fb_data_wr` stable.
  - On `fb_done`, go to CAPTURE.
  - If the watchdog reaches 0 first: `error`=1, go to FINISH.
- **CAPTURE:** on a load, store `fb_data_rd` into shadow byte idx. The bridge presents read data the cycle after `fb_done`.
  - If idx=3, go to FINISH.
  - Otherwise idx++ and go to ISSUE.
- **FINISH:** pulse `done` and drop `busy`.
  - **Load:** check `shadow0==MAGIC` and `shadow3==MAGIC^shadow1^shadow2`.
    - Pass: scores ← shadow1/shadow2, `valid`=1.
    - Fail: `error`=1, scores ← 0, `valid`=0.
  - **Save success:** scores ← latched inputs, `valid`=1.
  - **Any timeout:** scores and `valid` are unchanged.
- **Reset:** all outputs go to 0 except `fb_dir_rw`=1, and the state returns to IDLE.
  - `fb_dir_rw`=1 keeps the bridge data bus tri-stated.
  - A reset during an operation aborts it with no `done` pulse.

## Timing
- L = bridge latency: the number of cycles from `fb_start` high to `fb_done` high.
- Per byte: ISSUE (1 cycle) + WAIT (L cycles) + CAPTURE (1 cycle) = L+2 cycles.
- `busy` rises the cycle after the accepted request.
- `done` is registered and rises 4·(L+2)+1 cycles after the request cycle.
- `fb_start` is never high in two consecutive cycles, and never high while the bridge has not yet returned `fb_done` for the previous access.
- A `fb_done` seen outside WAIT is ignored.
- A timeout aborts the remaining bytes. A partially written record is left in flash and fails the next load's checksum.
- `error` and `valid` change only at FINISH, on an accepted request (clear `error`), or on reset.

## Structure
- **Package `flash_store_pkg`:**
  - state enum;
  - `REC_LEN`=4;
  - byte offsets `OFS_MAGIC`/`OFS_A`/`OFS_B`/`OFS_SUM`;
  - function `rec_sum(magic,a,b)`.
- **Sub-module `flash_access_watchdog`:** loadable 8-bit down-counter with `load`, `enable` and `expired` signals, instantiated once.
- **Bench:** a bridge model with configurable L and a 256-byte array.

## Test plan
- **Save:** L=5, save A=8'h07, B=8'h03 → writes 8'h10=A5, 8'h11=07, 8'h12=03, 8'h13=A1; `done` 29 cycles after the request; `valid`=1, `error`=0.
- **Load:** after the save, load → outputs 07/03, `valid`=1, `done` after 29 cycles; four `fb_start` pulses, each with `fb_dir_rw`=1.
- **Corrupt load:** model byte 8'h13 set to 8'h00, then load → `error`=1, `valid`=0, outputs 00/00.
- **Timeout:** model drops `fb_done` on byte 2 of a save with `TIMEOUT`=10 → `done`+`error` 10 cycles after that `fb_start`, no further `fb_start`, previous outputs retained.
- **Collisions:** `load_req` and `save_req` in the same cycle → save performed. A `load_req` during `busy` → ignored, exactly four accesses.
- **Mid-operation reset:** `RST` during WAIT of byte 1 → `fb_start`=0, `busy`=0, `fb_dir_rw`=1, no `done`; a subsequent load works normally.
